// File: rtl/sliding_tile_turn_sched.sv
// Turn scheduler for the 3x3 sliding tile puzzle: round-robin arbitration of two
// players, legality filtering against a mirrored space location, one move per turn.
module sliding_tile_turn_sched #(
    parameter int          CNT_W      = 8,
    parameter int          MAX_MOVES  = 200,
    parameter logic [3:0]  INIT_SPACE = 4'b1010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             p0_valid,
    input  logic [1:0]       p0_dir,
    output logic             p0_ready,
    input  logic             p1_valid,
    input  logic [1:0]       p1_dir,
    output logic             p1_ready,
    input  logic             solved,
    output logic             puzzle_reset,
    output logic             move_en,
    output logic [1:0]       move_dir,
    output logic [3:0]       space_loc,
    output logic [CNT_W-1:0] move_count,
    output logic [CNT_W-1:0] reject_count,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             winner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MOVES_LIM = CNT_W'(MAX_MOVES);

    state_t           state_r;
    logic             ptr_r;
    logic             grantee_r;
    logic             puzzle_reset_r;
    logic             move_en_r;
    logic [1:0]       move_dir_r;
    logic [3:0]       space_loc_r;
    logic [CNT_W-1:0] move_count_r;
    logic [CNT_W-1:0] reject_count_r;
    logic             busy_r;
    logic             done_r;
    logic             timeout_r;
    logic             winner_r;

    logic             grant_vld_s;
    logic             grant_idx_s;
    logic [1:0]       grant_dir_s;

    // Space location is {row, col}; a move is legal only if the space stays on the board.
    function automatic logic move_legal(input logic [1:0] dir, input logic [3:0] loc);
        case (dir)
            2'b00:   move_legal = (loc[1:0] != 2'd0);
            2'b01:   move_legal = (loc[1:0] <  2'd2);
            2'b10:   move_legal = (loc[3:2] != 2'd0);
            2'b11:   move_legal = (loc[3:2] <  2'd2);
            default: move_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] next_loc(input logic [1:0] dir, input logic [3:0] loc);
        case (dir)
            2'b00:   next_loc = {loc[3:2], loc[1:0] - 2'd1};
            2'b01:   next_loc = {loc[3:2], loc[1:0] + 2'd1};
            2'b10:   next_loc = {loc[3:2] - 2'd1, loc[1:0]};
            2'b11:   next_loc = {loc[3:2] + 2'd1, loc[1:0]};
            default: next_loc = loc;
        endcase
    endfunction

    // Round-robin grant; the pointer only breaks ties between simultaneous requests.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (p0_valid && p1_valid) begin
                grant_vld_s = 1'b1;
                grant_idx_s = ptr_r;
            end else if (p0_valid) begin
                grant_vld_s = 1'b1;
                grant_idx_s = 1'b0;
            end else if (p1_valid) begin
                grant_vld_s = 1'b1;
                grant_idx_s = 1'b1;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            grant_vld_s = 1'b0;
        end
        grant_dir_s = grant_idx_s ? p1_dir : p0_dir;
    end

    assign p0_ready = grant_vld_s & ~grant_idx_s;
    assign p1_ready = grant_vld_s &  grant_idx_s;

    // Turn FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            ptr_r          <= 1'b0;
            grantee_r      <= 1'b0;
            puzzle_reset_r <= 1'b0;
            move_en_r      <= 1'b0;
            move_dir_r     <= 2'b00;
            space_loc_r    <= INIT_SPACE;
            move_count_r   <= '0;
            reject_count_r <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            timeout_r      <= 1'b0;
            winner_r       <= 1'b0;
        end else begin
            puzzle_reset_r <= 1'b0;
            move_en_r      <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r        <= ST_CLEAR;
                        puzzle_reset_r <= 1'b1;
                        busy_r         <= 1'b1;
                        done_r         <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    move_count_r   <= '0;
                    reject_count_r <= '0;
                    timeout_r      <= 1'b0;
                    winner_r       <= 1'b0;
                    space_loc_r    <= INIT_SPACE;
                    state_r        <= ST_RUN;
                end
                ST_RUN: begin
                    if (grant_vld_s) begin
                        ptr_r <= ~grant_idx_s;
                        if (move_legal(grant_dir_s, space_loc_r)) begin
                            move_dir_r <= grant_dir_s;
                            grantee_r  <= grant_idx_s;
                            move_en_r  <= 1'b1;
                            state_r    <= ST_ISSUE;
                        end else if (reject_count_r != CNT_MAX) begin
                            reject_count_r <= reject_count_r + CNT_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    space_loc_r  <= next_loc(move_dir_r, space_loc_r);
                    move_count_r <= move_count_r + CNT_W'(1);
                    state_r      <= ST_CHECK;
                end
                ST_CHECK: begin
                    // The puzzle has applied the move by now, so solved reflects it.
                    if (solved) begin
                        winner_r <= grantee_r;
                        state_r  <= ST_DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else if (move_count_r == MOVES_LIM) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign puzzle_reset = puzzle_reset_r;
    assign move_en      = move_en_r;
    assign move_dir     = move_dir_r;
    assign space_loc    = space_loc_r;
    assign move_count   = move_count_r;
    assign reject_count = reject_count_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign timeout      = timeout_r;
    assign winner       = winner_r;

endmodule

// File: tb/tb_sliding_tile_turn_sched.sv
// Bench for sliding_tile_turn_sched: directed scenarios plus random play, all checked
// against a transaction-level game model (board position, counters, pending turn actions).
module tb_sliding_tile_turn_sched;

    localparam int         CNT_W = 8;
    localparam int         MAXM  = 4;
    localparam logic [3:0] INIT  = 4'b1010;

    logic             clk = 1'b0;
    logic             reset, start, solved;
    logic             p0_valid, p1_valid;
    logic [1:0]       p0_dir, p1_dir;
    logic             p0_ready, p1_ready, puzzle_reset, move_en;
    logic [1:0]       move_dir;
    logic [3:0]       space_loc;
    logic [CNT_W-1:0] move_count, reject_count;
    logic             busy, done, timeout, winner;

    sliding_tile_turn_sched #(.CNT_W(CNT_W), .MAX_MOVES(MAXM), .INIT_SPACE(INIT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p0_valid(p0_valid), .p0_dir(p0_dir), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_dir(p1_dir), .p1_ready(p1_ready),
        .solved(solved), .puzzle_reset(puzzle_reset), .move_en(move_en),
        .move_dir(move_dir), .space_loc(space_loc), .move_count(move_count),
        .reject_count(reject_count), .busy(busy), .done(done),
        .timeout(timeout), .winner(winner)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Game model: what each upcoming cycle owes the puzzle, plus board/counter state.
    typedef enum int {A_PRESET, A_MOVE, A_CHECK} act_t;
    act_t       m_q[$];
    bit         m_on, m_over, m_timeout, m_winner, m_ptr, m_mover;
    int         m_row, m_col, m_count, m_rej, solve_target;
    logic [1:0] m_dir;
    bit         last_ok, last_idx;

    function automatic bit legal_move(input logic [1:0] dir, input int row, input int col);
        case (dir)
            2'd0:    return col > 0;
            2'd1:    return col < 2;
            2'd2:    return row > 0;
            default: return row < 2;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_on = 0; m_over = 0; m_timeout = 0; m_winner = 0; m_ptr = 0; m_mover = 0;
        m_row = 2; m_col = 2; m_count = 0; m_rej = 0; m_dir = 2'd0;
    endtask

    task automatic model_edge(input bit g_ok, input bit g_idx);
        act_t       act;
        logic [1:0] dir;
        if (reset) begin
            model_reset();
        end else if (m_q.size() > 0) begin
            act = m_q.pop_front();
            case (act)
                A_PRESET: begin
                    m_count = 0; m_rej = 0; m_timeout = 0; m_winner = 0; m_row = 2; m_col = 2;
                end
                A_MOVE: begin
                    case (m_dir)
                        2'd0:    m_col--;
                        2'd1:    m_col++;
                        2'd2:    m_row--;
                        default: m_row++;
                    endcase
                    m_count++;
                end
                default: begin
                    if (solved) begin
                        m_winner = m_mover; m_on = 0; m_over = 1;
                    end else if (m_count == MAXM) begin
                        m_timeout = 1; m_on = 0; m_over = 1;
                    end
                end
            endcase
        end else if (m_on) begin
            if (g_ok) begin
                dir   = g_idx ? p1_dir : p0_dir;
                m_ptr = !g_idx;
                if (legal_move(dir, m_row, m_col)) begin
                    m_dir = dir; m_mover = g_idx;
                    m_q.push_back(A_MOVE);
                    m_q.push_back(A_CHECK);
                end else if (m_rej < 255) begin
                    m_rej++;
                end
            end
        end else if (start) begin
            m_on = 1; m_over = 0;
            m_q.push_back(A_PRESET);
            solve_target = $urandom_range(1, MAXM + 2);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] exp_loc;
        exp_loc = 4'(m_row * 4 + m_col);
        check_val("busy", busy, m_on);
        check_val("done", done, m_over);
        check_val("puzzle_reset", puzzle_reset, m_q.size() > 0 && m_q[0] == A_PRESET);
        check_val("move_en", move_en, m_q.size() > 0 && m_q[0] == A_MOVE);
        check_val("move_dir", move_dir, m_dir);
        check_val("space_loc", space_loc, exp_loc);
        check_val("move_count", move_count, m_count);
        check_val("reject_count", reject_count, m_rej);
        check_val("timeout", timeout, m_timeout);
        check_val("winner", winner, m_winner);
    endtask

    // One clock: inputs already driven at the negedge; check ready, advance model, check outputs.
    task automatic step();
        bit g_ok, g_idx;
        solved = (m_count >= solve_target);
        #1;
        g_ok  = m_on && m_q.size() == 0 && (p0_valid || p1_valid);
        g_idx = (p0_valid && p1_valid) ? m_ptr : p1_valid;
        check_val("p0_ready", p0_ready, g_ok && !g_idx);
        check_val("p1_ready", p1_ready, g_ok && g_idx);
        last_ok = g_ok; last_idx = g_idx;
        model_edge(g_ok, g_idx);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_and_start(input int target);
        p0_valid = 0; p1_valid = 0; start = 0;
        reset = 1; step(); step();
        reset = 0; start = 1; step();
        start = 0;
        check_val("clear_pulse", puzzle_reset, 1'b1);
        step();
        solve_target = target;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin step(); n++; end
        check_val(tag, done, 1'b1);
    endtask

    initial begin
        model_reset();
        solve_target = 1000;
        reset = 1; start = 0; p0_valid = 0; p1_valid = 0; p0_dir = 0; p1_dir = 0; solved = 0;
        @(negedge clk);
        step();
        check_val("rst_space", space_loc, INIT);
        check_val("rst_busy", busy, 1'b0);

        // Start, then p0 LEFT from the initial corner.
        reset_and_start(1000);
        check_val("run_space", space_loc, INIT);
        p0_valid = 1; p0_dir = 2'd0;
        step();
        p0_valid = 0;
        check_val("t2_move_en", move_en, 1'b1);
        check_val("t2_move_dir", move_dir, 2'd0);
        step();
        check_val("t2_space", space_loc, 4'b1001);
        check_val("t2_count", move_count, 1);
        step();

        // Illegal DOWN from the bottom row is dropped.
        p1_valid = 1; p1_dir = 2'd3;
        step();
        p1_valid = 0;
        check_val("t3_reject", reject_count, 1);
        check_val("t3_no_move", move_en, 1'b0);

        // Solve on the second move: p0 LEFT then p1 UP, winner is p1.
        reset_and_start(2);
        p0_valid = 1; p0_dir = 2'd0; p1_valid = 1; p1_dir = 2'd2;
        run_until_done("t5_done", 40);
        check_val("t5_winner", winner, 1'b1);
        check_val("t5_timeout", timeout, 1'b0);
        check_val("t5_space", space_loc, 4'b0101);
        repeat (4) step();
        start = 1; step(); start = 0;
        check_val("t5_restart", busy, 1'b1);

        // Move limit without a solve: LEFT/RIGHT ping-pong until timeout.
        reset_and_start(1000);
        p0_valid = 1; p0_dir = 2'd0; p1_valid = 1; p1_dir = 2'd1;
        run_until_done("t6_done", 60);
        check_val("t6_timeout", timeout, 1'b1);
        check_val("t6_count", move_count, MAXM);

        // Reject counter saturation: RIGHT is illegal from the initial corner.
        reset_and_start(1000);
        p0_valid = 1; p0_dir = 2'd1; p1_valid = 1; p1_dir = 2'd1;
        repeat (270) step();
        check_val("sat_reject", reject_count, 8'hFF);

        // Reset while a move is being issued.
        p1_valid = 0; p0_dir = 2'd0;
        step();
        p0_valid = 0;
        check_val("ri_move_en", move_en, 1'b1);
        reset = 1; step(); reset = 0;
        check_val("ri_move_en_off", move_en, 1'b0);
        check_val("ri_idle", busy, 1'b0);

        // Random play with spurious starts and occasional resets.
        last_ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!p0_valid || (last_ok && !last_idx)) begin
                p0_valid = ($urandom_range(0, 2) != 0);
                p0_dir   = 2'($urandom_range(0, 3));
            end
            if (!p1_valid || (last_ok && last_idx)) begin
                p1_valid = ($urandom_range(0, 2) != 0);
                p1_dir   = 2'($urandom_range(0, 3));
            end
            start = ($urandom_range(0, 5) == 0);
            if (m_q.size() > 0 && m_q[0] == A_MOVE)
                reset = ($urandom_range(0, 7) == 0);
            else
                reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 0; start = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
